mips_cpu_bus_arbiter: RTL and testbench
=======================================

# mips_cpu_bus_arbiter

Two-master, one-slave Avalon memory-mapped arbiter that shares the single memory bus slave (`mips_cpu_bus_memory`) between the CPU's instruction-fetch port and data (load/store) port. It sits between the CPU core and the memory controller, serialising transfers with a registered grant and a round-robin tie-break. It forwards `waitrequest` and `readdata` back to the granted master only.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (byteenable width is `DATA_W/8`).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_address`  in  ADDR_W  instruction master address.
- `i_read`  in  1  instruction master read request; the instruction master never writes.
- `i_waitrequest`  out  1  stall to instruction master.
- `i_readdata`  out  DATA_W  read data to instruction master.
- `d_address`  in  ADDR_W  data master address.
- `d_read`, `d_write`  in  1 each  data master requests; mutually exclusive.
- `d_writedata`  in  DATA_W  data master write data.
- `d_byteenable`  in  DATA_W/8  data master byte lanes.
- `d_waitrequest`  out  1  stall to data master.
- `d_readdata`  out  DATA_W  read data to data master.
- `m_address`  out  ADDR_W  address to memory slave.
- `m_read`, `m_write`  out  1 each  requests to memory slave.
- `m_writedata`  out  DATA_W  write data to memory slave.
- `m_byteenable`  out  DATA_W/8  byte lanes to memory slave.
- `m_waitrequest`  in  1  slave stall.
- `m_readdata`  in  DATA_W  slave read data.
- `grant`  out  2  debug: 2'b00 none, 2'b01 instruction, 2'b10 data.

## Operation
- FSM states: IDLE, GNT_I, GNT_D. The state register `last` (1 bit) records the most recently served master; it resets to instruction.
- IDLE:
  - Only the instruction master requests: go to GNT_I.
  - Only the data master requests: go to GNT_D.
  - Both request: grant the master not equal to `last`. After reset this gives data first.
- GNT_x, slave side: `m_*` are driven combinationally from master x. `m_read` = x read and `m_write` = x write. For the instruction master, `m_write`=0 and `m_byteenable`=all ones.
- GNT_x, master side:
  - x_waitrequest = `m_waitrequest`.
  - x_readdata = `m_readdata`.
  - The other master sees waitrequest=1 and readdata=0.
- Completion: a transfer completes in the GNT_x cycle where the request is asserted and `m_waitrequest`=0. On completion, `last` is set to x. The next state is the other master's GNT if that master is requesting, otherwise IDLE.
- Abort: if x drops its request while in GNT_x with no completion, return to IDLE. `last` is unchanged and nothing is forwarded that cycle.
- IDLE outputs:
  - `m_read`=`m_write`=0.
  - `m_address`, `m_writedata`, `m_byteenable` = 0.
  - Both master waitrequests = 1 if that master is requesting, else 0.
  - Both readdata = 0.
- `d_read` and `d_write` both high is illegal. The arbiter forwards `m_write`=0 and `m_read`=1, and holds `d_waitrequest`=1 until one of them drops.

## Timing
- Reset: while `rst_n`=0 at a clock edge, the state goes to IDLE and `last` to instruction. All `m_*` outputs read 0, both waitrequests 1, both readdata 0, `grant`=0. Reset mid-transfer abandons the transfer with no completion.
- Grant latency: a request seen in IDLE at edge N is granted from cycle N+1. Best-case transfer is 2 cycles (request cycle + granted cycle with `m_waitrequest`=0).
- Back-to-back: on completion, a pending other master is granted the next cycle with no IDLE bubble. The same master requesting again returns through IDLE if the other master is idle.
- No starvation: with both masters requesting continuously, grants strictly alternate I, D, I, D.
- Masters must hold address, data and request stable while their waitrequest=1. The arbiter adds no registers on the data path.

## Structure
- Shared package `mips_cpu_bus_pkg`:
  - `bus_state_t` enum {IDLE, GNT_I, GNT_D}.
  - `master_id_t` enum {MST_I, MST_D}.
  - Grant encoding constants.
- Single module. The request mux is inline and no sub-module is needed.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `i_read`=1 → `grant`=0, `m_read`=0, `i_waitrequest`=1. After release, `grant`=01 on the next cycle.
- Single fetch: `i_read`=1, `i_address`=0xBFC00000, slave returns 0x24020005 with 0 wait → `m_address`=0xBFC00000 in cycle 1, `i_readdata`=0x24020005, `i_waitrequest`=0 in cycle 1.
- Contention after reset: both request in the same cycle → data granted first. On completion the instruction master is granted the next cycle with no IDLE cycle.
- Store with waits: `d_write`=1, addr 0x00001004, data 0xDEADBEEF, `d_byteenable`=4'b0011, slave waitrequest=1 for 3 cycles:
  - `d_waitrequest`=1 for 3 cycles.
  - `m_*` stable throughout.
  - The instruction master is stalled throughout.
- Fairness: both request continuously for 8 transfers → grant sequence D, I, D, I, D, I, D, I.
- Abort and reset mid-transfer:
  - Abort: data master drops `d_read` during a wait → return to IDLE, and `last` stays instruction.
  - Reset: assert `rst_n`=0 during GNT_I → IDLE and all outputs at reset values next cycle.

Source files
------------

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the CPU memory-bus arbiter.
//   bus_state_t : arbiter FSM state (IDLE, GNT_I, GNT_D)
//   master_id_t : identifies a bus master (instruction or data)
//   GRANT_*     : encoding of the debug grant output
//   grant_code  : maps an FSM state onto its grant encoding
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } bus_state_t;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_id_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    function automatic logic [1:0] grant_code(input bus_state_t s);
        case (s)
            GNT_I:   return GRANT_I;
            GNT_D:   return GRANT_D;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter sharing the memory bus between
// the CPU instruction-fetch port (i_*) and the load/store port (d_*).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_address, i_read          instruction master request (read only)
//   i_waitrequest, i_readdata  instruction master response
//   d_address, d_read, d_write, d_writedata, d_byteenable
//                              data master request
//   d_waitrequest, d_readdata  data master response
//   m_*                        towards the memory slave
//   grant                      debug view of the FSM: 00 none, 01 I, 10 D
//
// Handshake: a master holds its request, address and data stable while its
// waitrequest is 1; a transfer completes in the first granted cycle where
// the request is high and the slave's waitrequest is 0. The slave path is
// purely combinational: the arbiter only registers who owns the bus.
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction master
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    // data master
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    // memory slave
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    // debug
    output logic [1:0]          grant
);

    bus_state_t state;
    master_id_t last;   // most recently served master, drives the tie-break

    logic i_req;
    logic d_req;
    logic d_illegal;
    logic i_done;
    logic d_done;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    // read+write together is illegal; it is stalled and never completes
    assign d_illegal = d_read & d_write;
    assign i_done    = (state == GNT_I) && i_req && !m_waitrequest;
    assign d_done    = (state == GNT_D) && d_req && !d_illegal && !m_waitrequest;

    // grant is a pure decode of the state register
    assign grant = grant_code(state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= MST_I;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req && d_req) begin
                        state <= (last == MST_I) ? GNT_D : GNT_I;
                    end else if (i_req) begin
                        state <= GNT_I;
                    end else if (d_req) begin
                        state <= GNT_D;
                    end
                end
                GNT_I: begin
                    if (i_done) begin
                        last  <= MST_I;
                        // hand straight over to a waiting data master
                        state <= d_req ? GNT_D : IDLE;
                    end else if (!i_req) begin
                        state <= IDLE;   // abort: last unchanged
                    end
                end
                GNT_D: begin
                    if (d_done) begin
                        last  <= MST_D;
                        state <= i_req ? GNT_I : IDLE;
                    end else if (!d_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        i_readdata    = '0;
        d_readdata    = '0;
        // ungranted master stalls only while it is actually requesting
        i_waitrequest = i_req;
        d_waitrequest = d_req;

        case (state)
            GNT_I: begin
                d_waitrequest = 1'b1;
                // a dropped request (abort) forwards nothing
                if (i_req) begin
                    m_address     = i_address;
                    m_read        = 1'b1;
                    m_byteenable  = '1;   // fetches are always full words
                    i_waitrequest = m_waitrequest;
                    i_readdata    = m_readdata;
                end
            end
            GNT_D: begin
                i_waitrequest = 1'b1;
                if (d_req) begin
                    m_address     = d_address;
                    m_read        = d_read;
                    m_write       = d_write & ~d_read;   // read wins if both set
                    m_writedata   = d_writedata;
                    m_byteenable  = d_byteenable;
                    d_waitrequest = m_waitrequest | d_illegal;
                    d_readdata    = m_readdata;
                end
            end
            default: ;
        endcase

        // nobody may complete anything while reset is held
        if (!rst_n) begin
            i_waitrequest = 1'b1;
            d_waitrequest = 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter: a cycle-by-cycle vector table
// (inputs applied for one cycle, outputs checked mid-cycle), followed by a
// hand-written fairness sequence under continuous contention.
module tb_mips_cpu_bus_arbiter;

    typedef struct {
        logic        rst_n;
        logic        i_read;
        logic [31:0] i_address;
        logic        d_read;
        logic        d_write;
        logic [31:0] d_address;
        logic [31:0] d_writedata;
        logic [3:0]  d_byteenable;
        logic        m_waitrequest;
        logic [31:0] m_readdata;
    } in_t;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] m_address;
        logic        m_read;
        logic        m_write;
        logic [31:0] m_writedata;
        logic [3:0]  m_byteenable;
        logic        i_waitrequest;
        logic [31:0] i_readdata;
        logic        d_waitrequest;
        logic [31:0] d_readdata;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [31:0] IA  = 32'hBFC0_0000;
    localparam logic [31:0] IR  = 32'h2402_0005;
    localparam logic [31:0] DA  = 32'h0000_1004;
    localparam logic [31:0] DW  = 32'hDEAD_BEEF;
    localparam logic [31:0] DA2 = 32'h0000_2000;
    localparam logic [31:0] DR  = 32'h1111_2222;
    localparam logic [31:0] MR  = 32'h55AA_55AA;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .grant         (grant)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    // ---------------- vector builders ----------------
    function automatic in_t iv(input logic rst, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dwr, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] be,
                               input logic mw, input logic [31:0] mrd);
        in_t v;
        v.rst_n = rst;   v.i_read = ir;      v.i_address = ia;
        v.d_read = dr;   v.d_write = dwr;    v.d_address = da;
        v.d_writedata = dwd; v.d_byteenable = be;
        v.m_waitrequest = mw; v.m_readdata = mrd;
        return v;
    endfunction

    function automatic out_t ov(input logic [1:0] g, input logic [31:0] ma,
                                input logic mr, input logic mwr, input logic [31:0] mwd,
                                input logic [3:0] mbe, input logic iw, input logic [31:0] ird,
                                input logic dw, input logic [31:0] drd);
        out_t v;
        v.grant = g;  v.m_address = ma; v.m_read = mr; v.m_write = mwr;
        v.m_writedata = mwd; v.m_byteenable = mbe;
        v.i_waitrequest = iw; v.i_readdata = ird;
        v.d_waitrequest = dw; v.d_readdata = drd;
        return v;
    endfunction

    function automatic out_t oi(input logic iw, input logic dw);
        return ov(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, iw, 32'h0, dw, 32'h0);
    endfunction

    function automatic out_t ogi(input logic [31:0] a, input logic iw, input logic [31:0] rd);
        return ov(2'b01, a, 1'b1, 1'b0, 32'h0, 4'hF, iw, rd, 1'b1, 32'h0);
    endfunction

    function automatic out_t ogd(input logic [31:0] a, input logic r, input logic w,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic dw, input logic [31:0] rd);
        return ov(2'b10, a, r, w, wd, be, 1'b1, 32'h0, dw, rd);
    endfunction

    vec_t vecs[$];

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input in_t v);
        rst_n         = v.rst_n;
        i_read        = v.i_read;
        i_address     = v.i_address;
        d_read        = v.d_read;
        d_write       = v.d_write;
        d_address     = v.d_address;
        d_writedata   = v.d_writedata;
        d_byteenable  = v.d_byteenable;
        m_waitrequest = v.m_waitrequest;
        m_readdata    = v.m_readdata;
    endtask

    task automatic check_outputs(input int row, input out_t e);
        chk("grant",         row, 32'(grant),         32'(e.grant));
        chk("m_address",     row, m_address,          e.m_address);
        chk("m_read",        row, 32'(m_read),        32'(e.m_read));
        chk("m_write",       row, 32'(m_write),       32'(e.m_write));
        chk("m_writedata",   row, m_writedata,        e.m_writedata);
        chk("m_byteenable",  row, 32'(m_byteenable),  32'(e.m_byteenable));
        chk("i_waitrequest", row, 32'(i_waitrequest), 32'(e.i_waitrequest));
        chk("i_readdata",    row, i_readdata,         e.i_readdata);
        chk("d_waitrequest", row, 32'(d_waitrequest), 32'(e.d_waitrequest));
        chk("d_readdata",    row, d_readdata,         e.d_readdata);
    endtask

    // ---------------- test ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    initial begin
        // reset hold, instruction master already requesting
        for (int k = 0; k < 3; k++)
            add(iv(0,1,IA,0,0,0,0,4'h0,0,IR), oi(1,1));
        // release: granted next cycle, single zero-wait fetch
        add(iv(1,1,IA,0,0,0,0,4'h0,0,IR), oi(1,0));
        add(iv(1,1,IA,0,0,0,0,4'h0,0,IR), ogi(IA,0,IR));
        add(iv(1,0,0,0,0,0,0,4'h0,0,0),    oi(0,0));
        // contention: data first, instruction follows with no idle cycle
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), oi(1,1));
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), ogd(DA2,1,0,0,4'hF,0,DR));
        add(iv(1,1,IA,0,0,0,0,4'h0,0,IR),   ogi(IA,0,IR));
        add(iv(1,0,0,0,0,0,0,4'h0,0,0),     oi(0,0));
        // store with three slave wait cycles, instruction stalled throughout
        add(iv(1,1,IA,0,1,DA,DW,4'h3,1,MR), oi(1,1));
        for (int k = 0; k < 3; k++)
            add(iv(1,1,IA,0,1,DA,DW,4'h3,1,MR), ogd(DA,0,1,DW,4'h3,1,MR));
        add(iv(1,1,IA,0,1,DA,DW,4'h3,0,MR), ogd(DA,0,1,DW,4'h3,0,MR));
        add(iv(1,1,IA,0,0,0,0,4'h0,0,IR),   ogi(IA,0,IR));
        add(iv(1,0,0,0,0,0,0,4'h0,0,0),     oi(0,0));
        // abort: data drops read mid-wait; tie-break must still favour data
        add(iv(1,0,0,1,0,DA2,0,4'hF,1,MR),  oi(0,1));
        add(iv(1,0,0,1,0,DA2,0,4'hF,1,MR),  ogd(DA2,1,0,0,4'hF,1,MR));
        add(iv(1,0,0,0,0,DA2,0,4'hF,1,MR),  ov(2'b10,0,0,0,0,4'h0,1,0,0,0));
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), oi(1,1));
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), ogd(DA2,1,0,0,4'hF,0,DR));
        // reset during a waiting instruction fetch
        add(iv(1,1,IA,0,0,0,0,4'h0,1,MR),   ogi(IA,1,MR));
        add(iv(0,1,IA,0,0,0,0,4'h0,1,MR),   ogi(IA,1,MR));
        add(iv(0,1,IA,0,0,0,0,4'h0,1,MR),   oi(1,1));
        // after reset the tie-break again favours data
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), oi(1,1));
        add(iv(1,1,IA,1,0,DA2,0,4'hF,0,DR), ogd(DA2,1,0,0,4'hF,0,DR));
        add(iv(1,1,IA,0,0,0,0,4'h0,0,IR),   ogi(IA,0,IR));
        add(iv(1,0,0,0,0,0,0,4'h0,0,0),     oi(0,0));
        // illegal read+write: forwarded as a read, stalled until one drops
        add(iv(1,0,0,1,1,DA,DW,4'hF,0,DR),  oi(0,1));
        add(iv(1,0,0,1,1,DA,DW,4'hF,0,DR),  ogd(DA,1,0,DW,4'hF,1,DR));
        add(iv(1,0,0,1,0,DA,DW,4'hF,0,DR),  ogd(DA,1,0,DW,4'hF,0,DR));
        add(iv(1,0,0,0,0,0,0,4'h0,0,0),     oi(0,0));

        // one reset edge so the state is known before the first row
        drive(vecs[0].i);
        @(posedge clk); #1;

        foreach (vecs[r]) begin
            drive(vecs[r].i);
            #1;
            check_outputs(r, vecs[r].o);
            @(posedge clk); #1;
        end

        // fairness: continuous contention, zero-wait slave
        drive(iv(0,1,IA,1,0,DA2,0,4'hF,0,DR));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(2'b10);
            exp_q.push_back(2'b01);
        end
        begin
            int idle_after = 0;
            for (int cyc = 0; cyc < 40 && got_q.size() < 8; cyc++) begin
                #1;
                if (grant != 2'b00) got_q.push_back(grant);
                else if (got_q.size() > 0) idle_after++;
                @(posedge clk); #1;
            end
            chk("fair_count", -1, 32'(got_q.size()), 32'd8);
            chk("fair_no_bubble", -1, 32'(idle_after), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < got_q.size()) chk("fair_grant", k, 32'(got_q[k]), 32'(exp_q[k]));
            else chk("fair_grant_missing", k, 32'hFFFF_FFFF, 32'(exp_q[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
